avg_unpool_2x: RTL
==================

Name: avg_unpool_2x

Overview:
- Streaming 2x nearest-neighbour upsampler: the decode side of the 2x2 sum-pooling stage.
- Accepts one 3-channel pooled sum per pixel in raster order. Each sum is divided by 4 to restore the average.
- Emits a 2x2 block of that average in full-resolution raster order: every value twice horizontally, every row twice vertically.
- Sits between the pooled feature map and the next full-resolution stage. Uses valid/ready on both sides because output rate is 4x input rate.

Parameters:
- CONV_BIT, 12, width of each output sample (signed); input sums are CONV_BIT+2 bits.
- HALF_WIDTH, 12, pooled pixels per row; output row = 2*HALF_WIDTH beats.
- HALF_HEIGHT, 12, pooled rows per frame; output frame = 2*HALF_HEIGHT rows.
- HALF_WIDTH_BIT, 4, width of column counter; must hold HALF_WIDTH-1.
- HALF_HEIGHT_BIT, 4, width of row counter; must hold HALF_HEIGHT-1.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  reset, synchronous, active-high.
- valid_in  input  1  pool_in_1..3 hold a valid pooled sum.
- ready_in  output  1  block accepts pool_in this cycle; transfer = valid_in && ready_in.
- pool_in_1, pool_in_2, pool_in_3  input  CONV_BIT+2 each  signed 2x2 sums, channels 1..3.
- ready_out  input  1  downstream accepts up_out this cycle.
- valid_out  output  1  up_out_1..3 valid; transfer = valid_out && ready_out.
- up_out_1, up_out_2, up_out_3  output  CONV_BIT each  signed upsampled averages.
- frame_done  output  1  one-cycle pulse after the last beat of a frame transfers.

Behaviour:
- Reset: valid_out=0, ready_in=0, frame_done=0, up_out_*=0. Column, row, phase and state are cleared to LIVE, column 0, copy A, row 0. Line buffer contents are don't-care.
- Arithmetic: up_out = pool_in >>> 2, arithmetic shift (floor toward -inf), truncated to CONV_BIT. Examples: 8188 -> 2047; -8192 -> -2048; -5 -> -2; 7 -> 1. All three channels are processed identically and in lockstep.
- Line buffer: HALF_WIDTH entries x 3 channels x CONV_BIT bits, holding the shifted values.
- State LIVE (first output row of a pair):
  - ready_in=1 only when next beat is copy A AND (valid_out=0 OR ready_out=1).
  - On accept: write buffer[col], load the output register, valid_out=1 next cycle, phase -> copy B.
  - On copy-A transfer: output register keeps the same value (copy B), valid_out stays 1, ready_in=0.
  - On copy-B transfer: col++. At col=HALF_WIDTH-1, col -> 0 and state -> REPLAY.
  - Copy-B transfer and the next input accept may coincide. Then the new value loads directly, with no bubble.
- State REPLAY (second output row of a pair):
  - ready_in=0. Emits buffer[0],buffer[0],buffer[1],buffer[1],... one beat per cycle while ready_out=1.
  - Load for the first REPLAY beat happens on the final LIVE copy-B transfer, with no bubble.
  - After the last copy-B transfer: col -> 0, state -> LIVE, row++.
  - At row=HALF_HEIGHT-1, row -> 0 and frame_done=1 in the next cycle for exactly one cycle.
- Latency: value accepted at edge k is on up_out with valid_out=1 from cycle k+1.
- Throughput: with ready_out=1 and valid_in=1 continuously, valid_out stays high without gaps.
  - Input is accepted at 1 per 2 cycles during LIVE and stalled for 2*HALF_WIDTH cycles during REPLAY.
- Backpressure: valid_out=1 && ready_out=0 holds up_out_*, valid_out, col, phase and state stable. ready_in=0 during the hold.
- Starvation: valid_in=0 in LIVE at copy A with the output consumed -> valid_out=0 next cycle; counters hold.
- valid_in while ready_in=0 is ignored; upstream must hold its data.
- Reset mid-frame aborts immediately. The next accepted input is treated as col 0, row 0.

Test Plan:
- HALF_WIDTH=2, HALF_HEIGHT=1, ready_out=1; inputs 40,-8 -> up_out sequence 10,10,-2,-2,10,10,-2,-2 on consecutive cycles. frame_done pulses once, the cycle after the 8th beat.
- Rounding/range: inputs 8188, -8192, -5, 7 on channel 1 with channels 2/3 = 4, -4 -> ch1 outputs 2047, -2048, -2, 1 (each doubled). ch2 gives 1, ch3 gives -1.
- Backpressure: ready_out low for 3 cycles during the copy-B beat -> up_out and valid_out stable. ready_in stays 0, no beat lost or duplicated, and total beat count = 4*HALF_WIDTH*HALF_HEIGHT.
- REPLAY stall: valid_in held 1 during REPLAY -> ready_in=0 for all 2*HALF_WIDTH replay beats. The next input is accepted in the cycle the last replay beat transfers.
- Starvation: valid_in gaps of 2 cycles between pixels -> valid_out drops to 0 during the gaps. Output sequence is unchanged.
- Reset at mid-REPLAY -> next cycle valid_out=0, frame_done=0. A fresh frame 4,8 (HALF_WIDTH=2) gives 1,1,2,2,1,1,2,2.

Source files
------------

// File: rtl/avg_unpool_2x.sv
// avg_unpool_2x: streaming 2x nearest-neighbour upsampler for 2x2 sum-pooled data.
// Each incoming 3-channel sum is divided by 4 (arithmetic shift) and emitted as a
// 2x2 block in full-resolution raster order. The first output row of a pair is
// produced live from the input; the second row is replayed from a line buffer.
module avg_unpool_2x #(
  parameter int CONV_BIT        = 12,
  parameter int HALF_WIDTH      = 12,
  parameter int HALF_HEIGHT     = 12,
  parameter int HALF_WIDTH_BIT  = 4,
  parameter int HALF_HEIGHT_BIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid_in,
  output logic                ready_in,
  input  logic [CONV_BIT+1:0] pool_in_1,
  input  logic [CONV_BIT+1:0] pool_in_2,
  input  logic [CONV_BIT+1:0] pool_in_3,
  input  logic                ready_out,
  output logic                valid_out,
  output logic [CONV_BIT-1:0] up_out_1,
  output logic [CONV_BIT-1:0] up_out_2,
  output logic [CONV_BIT-1:0] up_out_3,
  output logic                frame_done
);

  localparam int PIX_BIT = 3 * CONV_BIT;
  localparam logic [HALF_WIDTH_BIT-1:0]  COL_ZERO = {HALF_WIDTH_BIT{1'b0}};
  localparam logic [HALF_WIDTH_BIT-1:0]  COL_ONE  = HALF_WIDTH_BIT'(1);
  localparam logic [HALF_WIDTH_BIT-1:0]  COL_LAST = HALF_WIDTH_BIT'(HALF_WIDTH - 1);
  localparam logic [HALF_HEIGHT_BIT-1:0] ROW_ZERO = {HALF_HEIGHT_BIT{1'b0}};
  localparam logic [HALF_HEIGHT_BIT-1:0] ROW_ONE  = HALF_HEIGHT_BIT'(1);
  localparam logic [HALF_HEIGHT_BIT-1:0] ROW_LAST = HALF_HEIGHT_BIT'(HALF_HEIGHT - 1);

  // LIVE: first row of a pair, fed from the input. REPLAY: second row, from the buffer.
  typedef enum logic {ST_LIVE = 1'b0, ST_REPLAY = 1'b1} state_t;
  // Which copy of the current value is presented on up_out.
  typedef enum logic {PH_A = 1'b0, PH_B = 1'b1} phase_t;

  // Average of a 2x2 sum: floor(sum / 4), kept to CONV_BIT bits.
  function automatic logic [CONV_BIT-1:0] avg_of_sum(input logic [CONV_BIT+1:0] sum);
    return sum[CONV_BIT+1:2];
  endfunction

  state_t                     state_r;
  phase_t                     phase_r;
  logic [HALF_WIDTH_BIT-1:0]  col_r;
  logic [HALF_HEIGHT_BIT-1:0] row_r;
  logic                       valid_r;
  logic                       frame_done_r;
  logic [PIX_BIT-1:0]         data_r;
  logic [PIX_BIT-1:0]         line_buf_r [HALF_WIDTH];

  logic                       out_xfer_s;
  logic                       last_col_s;
  logic                       accept_ok_s;
  logic                       accept_s;
  logic [HALF_WIDTH_BIT-1:0]  col_next_s;
  logic [HALF_WIDTH_BIT-1:0]  wr_col_s;
  logic [PIX_BIT-1:0]         in_pix_s;

  assign out_xfer_s = valid_r && ready_out;
  assign last_col_s = (col_r == COL_LAST);
  assign col_next_s = col_r + COL_ONE;
  assign in_pix_s   = {avg_of_sum(pool_in_3), avg_of_sum(pool_in_2), avg_of_sum(pool_in_1)};
  assign accept_s   = accept_ok_s && valid_in;

  // Input may enter only when the next output beat is a fresh copy A; pick its column.
  always_comb begin
    accept_ok_s = 1'b0;
    wr_col_s    = col_r;
    if (rst) begin
      accept_ok_s = 1'b0;
    end else begin
      case (state_r)
        ST_LIVE: begin
          if (!valid_r) begin
            accept_ok_s = 1'b1;
            wr_col_s    = col_r;
          end else if (out_xfer_s && (phase_r == PH_B) && !last_col_s) begin
            accept_ok_s = 1'b1;
            wr_col_s    = col_next_s;
          end else begin
            accept_ok_s = 1'b0;
          end
        end
        ST_REPLAY: begin
          if (out_xfer_s && (phase_r == PH_B) && last_col_s) begin
            accept_ok_s = 1'b1;
            wr_col_s    = COL_ZERO;
          end else begin
            accept_ok_s = 1'b0;
          end
        end
        default: begin
          accept_ok_s = 1'b0;
        end
      endcase
    end
  end

  // Line buffer keeps the averaged pixels of the current row for the replay row.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      line_buf_r[wr_col_s] <= in_pix_s;
    end
  end

  // Output sequencer: copy A/B doubling, column/row tracking and LIVE/REPLAY switching.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_LIVE;
      phase_r      <= PH_A;
      col_r        <= COL_ZERO;
      row_r        <= ROW_ZERO;
      valid_r      <= 1'b0;
      frame_done_r <= 1'b0;
      data_r       <= {PIX_BIT{1'b0}};
    end else begin
      frame_done_r <= 1'b0;
      case (state_r)
        ST_LIVE: begin
          if (accept_s) begin
            data_r  <= in_pix_s;
            valid_r <= 1'b1;
            phase_r <= PH_A;
            col_r   <= wr_col_s;
          end else if (out_xfer_s) begin
            if (phase_r == PH_A) begin
              phase_r <= PH_B;
            end else if (last_col_s) begin
              // Load the first replay beat now so the row pair has no bubble.
              col_r   <= COL_ZERO;
              state_r <= ST_REPLAY;
              phase_r <= PH_A;
              data_r  <= line_buf_r[COL_ZERO];
            end else begin
              col_r   <= col_next_s;
              phase_r <= PH_A;
              valid_r <= 1'b0;
            end
          end
        end
        ST_REPLAY: begin
          if (out_xfer_s) begin
            if (phase_r == PH_A) begin
              phase_r <= PH_B;
            end else if (last_col_s) begin
              col_r   <= COL_ZERO;
              state_r <= ST_LIVE;
              phase_r <= PH_A;
              if (row_r == ROW_LAST) begin
                row_r        <= ROW_ZERO;
                frame_done_r <= 1'b1;
              end else begin
                row_r <= row_r + ROW_ONE;
              end
              // A pixel accepted on the last replay beat starts the next row directly.
              if (accept_s) begin
                data_r  <= in_pix_s;
                valid_r <= 1'b1;
              end else begin
                valid_r <= 1'b0;
              end
            end else begin
              col_r   <= col_next_s;
              phase_r <= PH_A;
              data_r  <= line_buf_r[col_next_s];
            end
          end
        end
        default: begin
          state_r <= ST_LIVE;
          phase_r <= PH_A;
          col_r   <= COL_ZERO;
          valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign ready_in   = accept_ok_s;
  assign valid_out  = valid_r;
  assign frame_done = frame_done_r;
  assign up_out_1   = data_r[CONV_BIT-1:0];
  assign up_out_2   = data_r[2*CONV_BIT-1:CONV_BIT];
  assign up_out_3   = data_r[3*CONV_BIT-1:2*CONV_BIT];

endmodule
